// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
//   slave  : controller side (receives start/opcode, drives controls)
//   master : datapath/sequencer side (drives start/opcode, receives controls)
// Signals:
//   start_i     - leave IDLE
//   Op_i        - opcode field of the instruction register
//   PCWrite_o .. ALUSrcA_o - single-bit datapath controls
//   PCSource_o  - PC mux select (00 ALU, 01 ALUOut, 10 jump target)
//   ALUSrcB_o   - ALU B mux select (00 B, 01 4, 10 imm, 11 imm<<2)
//   ALUOp_o     - 00 add, 01 sub, 10 funct decode
//   state_o     - current state encoding (debug)
//   illegal_o   - pulse on an unsupported opcode in DECODE
interface multicycle_control_if;
  logic       start_i;
  logic [5:0] Op_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       MemtoReg_o;
  logic       IRWrite_o;
  logic       RegWrite_o;
  logic       RegDst_o;
  logic       ALUSrcA_o;
  logic [1:0] PCSource_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic [3:0] state_o;
  logic       illegal_o;

  modport slave (
    input  start_i, Op_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           MemtoReg_o, IRWrite_o, RegWrite_o, RegDst_o, ALUSrcA_o,
           PCSource_o, ALUSrcB_o, ALUOp_o, state_o, illegal_o
  );

  modport master (
    output start_i, Op_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           MemtoReg_o, IRWrite_o, RegWrite_o, RegDst_o, ALUSrcA_o,
           PCSource_o, ALUSrcB_o, ALUOp_o, state_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS-like datapath.
// Memory states (FETCH, MEMRD, MEMWR) last MEM_LAT cycles each, timed by a
// wait counter; all other states last one cycle.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - control bundle (slave side), see multicycle_control_if
module multicycle_control #(
  parameter int MEM_LAT = 1
) (
  input logic clk_i,
  input logic rst_i,
  multicycle_control_if.slave bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADDR = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXEC    = 4'd7;
  localparam logic [3:0] S_RWB     = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_ADDIEX  = 4'd11;
  localparam logic [3:0] S_ADDIWB  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [5:0]    op_reg;
  logic          mem_state;
  logic          mem_done;

  assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                     (state_reg == S_MEMWR);
  assign mem_done  = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (bus.start_i) state_next = S_FETCH;
      S_FETCH:   if (mem_done) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op_i)
          OP_RTYPE:      state_next = S_EXEC;
          OP_ADDI:       state_next = S_ADDIEX;
          OP_LW, OP_SW:  state_next = S_MEMADDR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          default:       state_next = S_FETCH;
        endcase
      end
      // Path choice uses the opcode captured in DECODE, not the live input.
      S_MEMADDR: state_next = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_done) state_next = S_MEMWB;
      S_MEMWR:   if (mem_done) state_next = S_FETCH;
      S_EXEC:    state_next = S_RWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // The counter restarts on every state change, so it reads 0 on entry to
  // each memory state and only advances while waiting inside one.
  always_comb begin
    cnt_next = '0;
    if (mem_state && (state_next == state_reg))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_DECODE)
        op_reg <= bus.Op_i;
    end
  end

  always_comb begin
    bus.PCWrite_o     = 1'b0;
    bus.PCWriteCond_o = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.MemRead_o     = 1'b0;
    bus.MemWrite_o    = 1'b0;
    bus.MemtoReg_o    = 1'b0;
    bus.IRWrite_o     = 1'b0;
    bus.RegWrite_o    = 1'b0;
    bus.RegDst_o      = 1'b0;
    bus.ALUSrcA_o     = 1'b0;
    bus.PCSource_o    = 2'b00;
    bus.ALUSrcB_o     = 2'b00;
    bus.ALUOp_o       = 2'b00;
    bus.illegal_o     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        bus.MemRead_o = 1'b1;
        bus.ALUSrcB_o = 2'b01;
        // IR and PC update only once the memory data is valid.
        bus.IRWrite_o = mem_done;
        bus.PCWrite_o = mem_done;
      end
      S_DECODE: begin
        bus.ALUSrcB_o = 2'b11;
        // Only output that looks at an input: flags the opcode being decoded.
        case (bus.Op_i)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: bus.illegal_o = 1'b0;
          default: bus.illegal_o = 1'b1;
        endcase
      end
      S_MEMADDR, S_ADDIEX: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead_o = 1'b1;
        bus.IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite_o = 1'b1;
        bus.MemtoReg_o = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite_o = 1'b1;
        bus.IorD_o     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUOp_o   = 2'b10;
      end
      S_RWB: begin
        bus.RegDst_o   = 1'b1;
        bus.RegWrite_o = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA_o     = 1'b1;
        bus.ALUOp_o       = 2'b01;
        bus.PCWriteCond_o = 1'b1;
        bus.PCSource_o    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite_o  = 1'b1;
        bus.PCSource_o = 2'b10;
      end
      S_ADDIWB: bus.RegWrite_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_o = state_reg;

endmodule
